// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Avalon bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic master_id_t;

  // Device field codes carried in Addr[15:12]
  localparam logic [3:0]  DEV_MEM          = 4'h0;
  localparam logic [3:0]  DEV_FP           = 4'h1;
  localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

endpackage

// File: rtl/avalon_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: sole requester wins, a tie goes to the master
// that did not own the last completed transaction.
module rr_pick2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  output logic       grant_valid,
  output master_id_t grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-master round-robin arbiter for the 16-bit Avalon data bus; one whole
// transaction per grant. Optional slave watchdog under BUS_ARB_TIMEOUT_EN.
module avalon_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [15:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        M0_Read,
  input  logic        M0_Write,
  input  logic [15:0] M0_Addr,
  input  logic [15:0] M0_WrData,
  output logic [15:0] M0_RdData,
  output logic        M0_Waitreq,
  input  logic        M1_Read,
  input  logic        M1_Write,
  input  logic [15:0] M1_Addr,
  input  logic [15:0] M1_WrData,
  output logic [15:0] M1_RdData,
  output logic        M1_Waitreq,
  output logic        S_Read,
  output logic        S_Write,
  output logic [15:0] S_Addr,
  output logic [15:0] S_WrData,
  input  logic [15:0] S_RdData,
  input  logic        S_Waitreq,
  output logic        GrantId,
  output logic        BusErr
);

  arb_state_t  state, state_nx;
  master_id_t  grant_id, last_grant, pick_id;
  logic        pick_valid, take, done, abort;
  logic        lat_read, lat_write;
  logic [15:0] lat_addr, lat_wrdata;
  logic [15:0] hold0, hold1, done_data;
  logic        win_read, win_write;
  logic [15:0] win_addr, win_wrdata;

  rr_pick2 u_pick (
    .req         ({M1_Read | M1_Write, M0_Read | M0_Write}),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  assign win_read   = pick_id ? M1_Read   : M0_Read;
  assign win_write  = pick_id ? M1_Write  : M0_Write;
  assign win_addr   = pick_id ? M1_Addr   : M0_Addr;
  assign win_wrdata = pick_id ? M1_WrData : M0_WrData;
  assign take       = (state == IDLE) && pick_valid;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;

  // Counts stalled BUSY cycles; any other cycle (including IDLE) clears it
  always_ff @(posedge Clock) begin
    if (Reset || state != BUSY || !S_Waitreq) tcnt <= '0;
    else                                      tcnt <= tcnt + CW'(1);
  end

  assign abort     = (state == BUSY) && S_Waitreq && (tcnt == CW'(TIMEOUT_CYCLES - 1));
  assign done_data = abort ? ERR_DATA : S_RdData;
  logic unused_cfg;
  assign unused_cfg = ^{DEV_MEM, DEV_FP};
`else
  assign abort     = 1'b0;
  assign done_data = S_RdData;
  logic unused_cfg;
  assign unused_cfg = ^{DEV_MEM, DEV_FP, ERR_DATA, 32'(TIMEOUT_CYCLES)};
`endif

  assign done    = (state == BUSY) && (!S_Waitreq || abort);
  assign BusErr  = abort;
  assign GrantId = grant_id;
  assign S_Addr  = lat_addr;
  assign S_WrData = lat_wrdata;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wrdata <= '0;
      hold0      <= '0;
      hold1      <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        grant_id   <= pick_id;
        lat_write  <= win_write;
        lat_read   <= win_read & ~win_write;
        lat_addr   <= win_addr;
        lat_wrdata <= win_wrdata;
      end
      if (done) begin
        last_grant <= grant_id;
        if (grant_id == 1'b0) hold0 <= done_data;
        else                  hold1 <= done_data;
      end
    end
  end

  // Completing master sees slave data combinationally; the other holds its last value
  always_comb begin
    state_nx   = state;
    S_Read     = 1'b0;
    S_Write    = 1'b0;
    M0_Waitreq = 1'b1;
    M1_Waitreq = 1'b1;
    M0_RdData  = hold0;
    M1_RdData  = hold1;
    case (state)
      IDLE: if (pick_valid) state_nx = BUSY;
      BUSY: begin
        S_Read  = lat_read;
        S_Write = lat_write;
        if (done) begin
          state_nx = IDLE;
          if (grant_id == 1'b0) begin
            M0_Waitreq = 1'b0;
            M0_RdData  = done_data;
          end else begin
            M1_Waitreq = 1'b0;
            M1_RdData  = done_data;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_avalon_bus_arbiter;

  localparam int unsigned TO = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        M0_Read = 0, M0_Write = 0, M1_Read = 0, M1_Write = 0;
  logic [15:0] M0_Addr = 0, M0_WrData = 0, M1_Addr = 0, M1_WrData = 0;
  logic [15:0] M0_RdData, M1_RdData, S_Addr, S_WrData;
  logic        M0_Waitreq, M1_Waitreq, S_Read, S_Write, GrantId, BusErr;
  logic [15:0] S_RdData = 0;
  logic        S_Waitreq = 0;

  int checks = 0;
  int failures = 0;

  avalon_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(16'hDEAD)) dut (
    .Clock(Clock), .Reset(Reset),
    .M0_Read(M0_Read), .M0_Write(M0_Write), .M0_Addr(M0_Addr), .M0_WrData(M0_WrData),
    .M0_RdData(M0_RdData), .M0_Waitreq(M0_Waitreq),
    .M1_Read(M1_Read), .M1_Write(M1_Write), .M1_Addr(M1_Addr), .M1_WrData(M1_WrData),
    .M1_RdData(M1_RdData), .M1_Waitreq(M1_Waitreq),
    .S_Read(S_Read), .S_Write(S_Write), .S_Addr(S_Addr), .S_WrData(S_WrData),
    .S_RdData(S_RdData), .S_Waitreq(S_Waitreq),
    .GrantId(GrantId), .BusErr(BusErr)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record plus fairness memory
  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  bit          m_busy  = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last  = 1'b1;
  int unsigned m_waits = 0;
  txn_t        m_txn   = '0;
  logic [15:0] m_hold [2] = '{16'h0, 16'h0};
  bit          fin [2] = '{1'b0, 1'b0};

  always @(posedge Clock) begin
    bit       ab, dn;
    bit [1:0] req;
    fin[0] = 1'b0;
    fin[1] = 1'b0;
    if (Reset) begin
      m_busy = 1'b0; m_last = 1'b1; m_waits = 0; m_txn = '0;
      m_hold[0] = 16'h0; m_hold[1] = 16'h0;
    end else if (!m_busy) begin
      req = {M1_Read | M1_Write, M0_Read | M0_Write};
      if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? !m_last : req[1];
        m_txn   = m_owner ? '{wr: M1_Write, addr: M1_Addr, wdata: M1_WrData}
                          : '{wr: M0_Write, addr: M0_Addr, wdata: M0_WrData};
        m_busy  = 1'b1;
        m_waits = 0;
      end
    end else begin
      ab = TO_EN && S_Waitreq && (m_waits == TO - 1);
      dn = !S_Waitreq || ab;
      if (dn) begin
        m_hold[m_owner] = ab ? 16'hDEAD : S_RdData;
        m_last = m_owner;
        m_busy = 1'b0;
        fin[m_owner] = 1'b1;
      end else begin
        m_waits++;
      end
    end
  end

  always @(negedge Clock) begin
    bit          ab, dn, d0, d1;
    logic [15:0] dd;
    ab = m_busy && TO_EN && S_Waitreq && (m_waits == TO - 1);
    dn = m_busy && (!S_Waitreq || ab);
    dd = ab ? 16'hDEAD : S_RdData;
    d0 = dn && !m_owner;
    d1 = dn && m_owner;
    chk("m_S_Read",  16'(S_Read),  16'(m_busy && !m_txn.wr));
    chk("m_S_Write", 16'(S_Write), 16'(m_busy && m_txn.wr));
    chk("m_S_Addr",   S_Addr,   m_txn.addr);
    chk("m_S_WrData", S_WrData, m_txn.wdata);
    chk("m_M0_Waitreq", 16'(M0_Waitreq), 16'(!d0));
    chk("m_M1_Waitreq", 16'(M1_Waitreq), 16'(!d1));
    chk("m_M0_RdData", M0_RdData, d0 ? dd : m_hold[0]);
    chk("m_M1_RdData", M1_RdData, d1 ? dd : m_hold[1]);
    chk("m_BusErr", 16'(BusErr), 16'(ab));
    if (m_busy) chk("m_GrantId", 16'(GrantId), 16'(m_owner));
  end

  task automatic nxt();
    @(posedge Clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge Clock);
    #1;
  endtask

  task automatic wait_done(input int m, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      at_neg();
      if ((m == 0 && !M0_Waitreq) || (m == 1 && !M1_Waitreq)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_done_m%0d: no completion within %0d cycles", m, budget);
    end
  endtask

  task automatic wait_any(input int budget, output int who, output int iters);
    who = -1;
    iters = 0;
    for (int i = 0; i < budget; i++) begin
      at_neg();
      iters++;
      if (!M0_Waitreq) begin who = 0; break; end
      if (!M1_Waitreq) begin who = 1; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          who, iters;
    bit          act [2];
    logic        rd [2], wr [2];
    logic [15:0] ad [2], wd [2];

    // Reset state
    repeat (2) @(posedge Clock);
    at_neg();
    chk("rst_M0_Waitreq", 16'(M0_Waitreq), 16'h1);
    chk("rst_M1_Waitreq", 16'(M1_Waitreq), 16'h1);
    chk("rst_S_Read", 16'(S_Read), 16'h0);
    chk("rst_S_Addr", S_Addr, 16'h0);
    chk("rst_M0_RdData", M0_RdData, 16'h0);
    chk("rst_GrantId", 16'(GrantId), 16'h0);
    chk("rst_BusErr", 16'(BusErr), 16'h0);
    nxt(); Reset = 1'b0;

    // Single zero-wait read by M0
    nxt(); M0_Read = 1; M0_Addr = 16'h0010; S_Waitreq = 0; S_RdData = 16'h1234;
    at_neg();
    chk("t1_idle_S_Read", 16'(S_Read), 16'h0);
    chk("t1_idle_M0_Waitreq", 16'(M0_Waitreq), 16'h1);
    nxt(); at_neg();
    chk("t1_S_Read", 16'(S_Read), 16'h1);
    chk("t1_S_Addr", S_Addr, 16'h0010);
    chk("t1_M0_Waitreq", 16'(M0_Waitreq), 16'h0);
    chk("t1_M0_RdData", M0_RdData, 16'h1234);
    nxt(); M0_Read = 0; S_RdData = 16'h7777;
    at_neg();
    chk("t1_after_Waitreq", 16'(M0_Waitreq), 16'h1);
    chk("t1_hold_RdData", M0_RdData, 16'h1234);
    chk("t1_after_S_Read", 16'(S_Read), 16'h0);

    // Read and write together: write wins
    nxt(); M0_Read = 1; M0_Write = 1; M0_Addr = 16'h0020; M0_WrData = 16'h5555;
    at_neg();
    nxt(); at_neg();
    chk("t6_S_Write", 16'(S_Write), 16'h1);
    chk("t6_S_Read", 16'(S_Read), 16'h0);
    chk("t6_S_WrData", S_WrData, 16'h5555);
    chk("t6_M0_Waitreq", 16'(M0_Waitreq), 16'h0);

    // Tie after M0 finished last: M1 write wins and waits 3 cycles
    nxt(); M0_Read = 1; M0_Write = 0; M0_Addr = 16'h0030;
    M1_Write = 1; M1_Addr = 16'h1002; M1_WrData = 16'hBEEF; S_Waitreq = 1;
    at_neg();
    for (int i = 1; i <= 4; i++) begin
      nxt();
      if (i == 2) begin M1_Addr = 16'hFFFF; M1_WrData = 16'h0000; end
      if (i == 4) S_Waitreq = 0;
      at_neg();
      chk("t3_S_Write", 16'(S_Write), 16'h1);
      chk("t3_S_Addr", S_Addr, 16'h1002);
      chk("t3_S_WrData", S_WrData, 16'hBEEF);
      chk("t3_GrantId", 16'(GrantId), 16'h1);
      chk("t3_M0_Waitreq", 16'(M0_Waitreq), 16'h1);
      chk("t3_M1_Waitreq", 16'(M1_Waitreq), (i == 4) ? 16'h0 : 16'h1);
    end
    nxt(); M1_Write = 0; S_RdData = 16'h4321;
    wait_done(0, 10);
    chk("t3_M0_RdData", M0_RdData, 16'h4321);
    nxt(); M0_Read = 0;

    // Reset mid-wait, then a tie must go to M0 even though M0 finished last
    M0_Read = 1; M0_Addr = 16'h0040; S_Waitreq = 1;
    nxt(); nxt(); at_neg();
    chk("t5_busy_S_Read", 16'(S_Read), 16'h1);
    nxt(); Reset = 1;
    nxt(); Reset = 0; M1_Read = 1; M1_Addr = 16'h0050;
    at_neg();
    chk("t5_S_Read", 16'(S_Read), 16'h0);
    chk("t5_M0_Waitreq", 16'(M0_Waitreq), 16'h1);
    chk("t5_M1_Waitreq", 16'(M1_Waitreq), 16'h1);
    nxt(); at_neg();
    chk("t5_GrantId", 16'(GrantId), 16'h0);
    chk("t5_S_Addr", S_Addr, 16'h0040);
    nxt(); S_Waitreq = 0;
    wait_done(0, 4);
    nxt(); M0_Read = 0;
    wait_done(1, 6);
    nxt(); M1_Read = 0;

    // Continuous requests from both: strict alternation with one IDLE gap
    M0_Read = 1; M1_Read = 1; S_Waitreq = 0;
    for (int k = 0; k < 6; k++) begin
      S_RdData = 16'(16'hA000 + k);
      wait_any(6, who, iters);
      chk("t2_winner", 16'(who), 16'(k % 2));
      if (k > 0) chk("t2_gap", 16'(iters), 16'h1);
      at_neg();
      chk("t2_idle_S_Read", 16'(S_Read), 16'h0);
    end
    nxt(); M0_Read = 0; M1_Read = 0;

    // Hung slave
    M0_Read = 1; M0_Addr = 16'h0060; S_Waitreq = 1;
    at_neg();
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      nxt(); at_neg();
      chk("t4_M0_Waitreq", 16'(M0_Waitreq), (i == 4) ? 16'h0 : 16'h1);
      chk("t4_BusErr", 16'(BusErr), (i == 4) ? 16'h1 : 16'h0);
      if (i == 4) chk("t4_M0_RdData", M0_RdData, 16'hDEAD);
    end
    nxt(); M0_Read = 0;
    at_neg();
    chk("t4_after_BusErr", 16'(BusErr), 16'h0);
    chk("t4_after_S_Read", 16'(S_Read), 16'h0);
`else
    repeat (100) nxt();
    at_neg();
    chk("t4_stall_M0_Waitreq", 16'(M0_Waitreq), 16'h1);
    chk("t4_stall_BusErr", 16'(BusErr), 16'h0);
    chk("t4_stall_S_Read", 16'(S_Read), 16'h1);
    nxt(); S_Waitreq = 0;
    wait_done(0, 4);
    nxt(); M0_Read = 0;
`endif

    // Random traffic obeying the hold-until-done protocol
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; rd[m] = 0; wr[m] = 0; ad[m] = 0; wd[m] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      nxt();
      Reset     = ($urandom_range(0, 299) == 0);
      S_Waitreq = ($urandom_range(0, 2) == 0);
      S_RdData  = 16'($urandom);
      for (int m = 0; m < 2; m++) begin
        if (act[m] && fin[m]) begin
          act[m] = 0; rd[m] = 0; wr[m] = 0;
        end
        if (!act[m] && $urandom_range(0, 2) == 0) begin
          act[m] = 1;
          case ($urandom_range(0, 3))
            0:       begin rd[m] = 1; wr[m] = 1; end
            1:       begin rd[m] = 0; wr[m] = 1; end
            default: begin rd[m] = 1; wr[m] = 0; end
          endcase
          ad[m] = 16'($urandom);
          wd[m] = 16'($urandom);
        end else if (act[m] && $urandom_range(0, 3) == 0) begin
          ad[m] = 16'($urandom);
          wd[m] = 16'($urandom);
        end
      end
      M0_Read = rd[0]; M0_Write = wr[0]; M0_Addr = ad[0]; M0_WrData = wd[0];
      M1_Read = rd[1]; M1_Write = wr[1]; M1_Addr = ad[1]; M1_WrData = wd[1];
    end
    nxt();
    Reset = 0; M0_Read = 0; M0_Write = 0; M1_Read = 0; M1_Write = 0; S_Waitreq = 0;
    repeat (3) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
